// File: rtl/econ_selftest_seq_if.sv
// Handshake bundle between the self-test sequencer (master) and the device under test (slave).
interface econ_selftest_seq_if #(
  parameter int IN_W  = 1056,
  parameter int OUT_W = 220
);
  logic [IN_W-1:0]  dut_in_dat;
  logic             dut_in_vld;
  logic [OUT_W-1:0] dut_out_dat;
  logic             dut_out_vld;

  modport master (output dut_in_dat, dut_in_vld, input dut_out_dat, dut_out_vld);
  modport slave  (input dut_in_dat, dut_in_vld, output dut_out_dat, dut_out_vld);
endinterface

// File: rtl/econ_selftest_seq.sv
// Self-test sequencer: replays stored stimulus/expected pairs through an external DUT and scores the responses.
// 3 cycles per vector with an immediate response plus one FIN cycle; start and loads are ignored while busy.
module econ_selftest_seq #(
  parameter int  IN_W  = 1056,
  parameter int  OUT_W = 220,
  parameter int  DEPTH = 64,
  parameter int  TO_W  = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_we,
  input  logic [IDX_W-1:0]    ld_addr,
  input  logic [IN_W-1:0]     ld_in,
  input  logic [OUT_W-1:0]    ld_exp,
  input  logic                start,
  input  logic                sweep,
  input  logic [IDX_W-1:0]    idx_lo,
  input  logic [IDX_W-1:0]    idx_hi,
  input  logic [TO_W-1:0]     timeout,
  econ_selftest_seq_if.master dut,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [IDX_W:0]      err_cnt,
  output logic [IDX_W-1:0]    first_err_idx,
  output logic                to_flag
);
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {IDLE, DRIVE, WAIT, NEXT, FIN} state_t;
  state_t state, state_nxt;

  logic [IN_W-1:0]  mem_in  [DEPTH];
  logic [OUT_W-1:0] mem_exp [DEPTH];

  logic             sweep_q;
  logic [IDX_W-1:0] hi_q;
  logic [IDX_W-1:0] cur_idx;
  logic [TO_W-1:0]  to_lim;
  logic [TO_W-1:0]  to_cnt;
  logic [OUT_W-1:0] exp_q;
  logic [IN_W-1:0]  in_dat_q;

  logic             last_vec;
  logic             to_hit;
  logic             err_ev;
  logic [TO_W-1:0]  to_cnt_inc;
  logic [IDX_W-1:0] idx_inc;

  always_comb begin
    to_cnt_inc = to_cnt + TO_W'(1);
    idx_inc    = (cur_idx == IDX_W'(DEPTH - 1)) ? '0 : cur_idx + IDX_W'(1);
    last_vec   = !sweep_q || (cur_idx == hi_q);
    // A response arriving in the same cycle the limit is reached wins over the timeout.
    to_hit     = (state == WAIT) && !dut.dut_out_vld && (to_lim != '0) && (to_cnt_inc == to_lim);
    err_ev     = (state == WAIT) &&
                 ((dut.dut_out_vld && (dut.dut_out_dat != exp_q)) || to_hit);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = DRIVE;
      DRIVE:   state_nxt = WAIT;
      WAIT:    if (dut.dut_out_vld || to_hit) state_nxt = NEXT;
      NEXT:    state_nxt = last_vec ? FIN : DRIVE;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy           = (state != IDLE);
  assign done           = (state == FIN);
  assign dut.dut_in_vld = (state == WAIT);
  assign dut.dut_in_dat = in_dat_q;

  // Vector memory has no reset; contents survive a run abort.
  always_ff @(posedge clk) begin
    if (ld_we && (state == IDLE)) begin
      mem_in[ld_addr]  <= ld_in;
      mem_exp[ld_addr] <= ld_exp;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sweep_q       <= 1'b0;
      hi_q          <= '0;
      cur_idx       <= '0;
      to_lim        <= '0;
      to_cnt        <= '0;
      exp_q         <= '0;
      in_dat_q      <= '0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      to_flag       <= 1'b0;
      pass          <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          sweep_q <= sweep;
          hi_q    <= idx_hi;
          to_lim  <= timeout;
          cur_idx <= idx_lo;
          err_cnt <= '0;
          to_flag <= 1'b0;
          pass    <= 1'b0;
        end
        DRIVE: begin
          in_dat_q <= mem_in[cur_idx];
          exp_q    <= mem_exp[cur_idx];
          to_cnt   <= '0;
        end
        WAIT: if (!dut.dut_out_vld && (to_lim != '0)) to_cnt <= to_cnt_inc;
        NEXT: begin
          // err_cnt is final here, so pass is already valid alongside done.
          if (!last_vec) cur_idx <= idx_inc;
          else           pass    <= (err_cnt == '0);
        end
        default: ;
      endcase
      if (err_ev) begin
        if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        if (err_cnt == '0) first_err_idx <= cur_idx;
        if (to_hit)        to_flag <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_econ_selftest_seq.sv
// Self-checking bench: echo DUT model, run table plus abort, busy-ignore and load-with-start sequences.
module tb_econ_selftest_seq;
  localparam int IN_W = 1056, OUT_W = 220, DEPTH = 64, TO_W = 16, IDX_W = 6;

  logic             clk = 1'b0, rst = 1'b0;
  logic             ld_we = 1'b0, start = 1'b0, sweep = 1'b0;
  logic [IDX_W-1:0] ld_addr = '0, idx_lo = '0, idx_hi = '0;
  logic [IN_W-1:0]  ld_in = '0;
  logic [OUT_W-1:0] ld_exp = '0;
  logic [TO_W-1:0]  timeout = '0;
  logic             busy, done, pass, to_flag;
  logic [IDX_W:0]   err_cnt;
  logic [IDX_W-1:0] first_err_idx;

  econ_selftest_seq_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  econ_selftest_seq #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .TO_W(TO_W)) u_dut (
    .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_in(ld_in), .ld_exp(ld_exp),
    .start(start), .sweep(sweep), .idx_lo(idx_lo), .idx_hi(idx_hi), .timeout(timeout),
    .dut(bus), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_err_idx(first_err_idx), .to_flag(to_flag));

  always #5 clk = ~clk;

  // Echo DUT: returns the low OUT_W bits of the stimulus in the echo_d-th valid cycle (0 = never).
  int echo_d = 0;
  int vcnt = 0;
  always @(posedge clk) vcnt <= bus.dut_in_vld ? vcnt + 1 : 0;
  assign bus.dut_out_vld = bus.dut_in_vld && (echo_d != 0) && (vcnt == echo_d - 1);
  assign bus.dut_out_dat = bus.dut_in_dat[OUT_W-1:0];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int id; bit sw; int lo; int hi; int to; int d;
    int e_err; int e_first; bit e_pass; bit e_to; int e_lat; int e_vld;
  } vec_t;
  typedef struct {
    int id; int e_err; int e_first; bit e_pass; bit e_to; int e_lat; int e_vld; int t0;
  } exp_t;

  vec_t             tbl [9];
  exp_t             sb [$];
  int               idx_q [$];
  logic [IN_W-1:0]  m_in  [DEPTH];
  logic [OUT_W-1:0] m_exp [DEPTH];
  int               n_tests = 0, n_fail = 0;
  int               dn_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", nm, act, req);
    end
  endtask

  task automatic chk_wide(input string nm, input logic [IN_W-1:0] act, input logic [IN_W-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got low64 %h, want low64 %h", nm, act[63:0], req[63:0]);
    end
  endtask

  function automatic logic [IN_W-1:0] rnd_vec();
    logic [IN_W-1:0] v;
    for (int i = 0; i < IN_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Monitor: checks stimulus per WAIT entry against the memory model, and run results at done.
  initial begin
    bit              prev_vld = 1'b0;
    logic [IN_W-1:0] prev_dat = '0;
    int              vcyc = 0;
    int              ix;
    exp_t            r;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_vld = 1'b0;
        vcyc = 0;
      end else begin
        if (bus.dut_in_vld) begin
          vcyc++;
          if (!prev_vld) begin
            if (idx_q.size() == 0) begin
              n_tests++; n_fail++;
              $display("FAIL unexpected_vector: got in_vld=1, want no vector pending");
            end else begin
              ix = idx_q.pop_front();
              chk_wide($sformatf("in_dat_slot%0d", ix), bus.dut_in_dat, m_in[ix]);
            end
          end else chk_wide("in_dat_stable", bus.dut_in_dat, prev_dat);
          prev_dat = bus.dut_in_dat;
        end
        prev_vld = bus.dut_in_vld;
        if (done) begin
          dn_cnt++;
          if (sb.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_done: got done=1, want no run pending");
          end else begin
            r = sb.pop_front();
            chk($sformatf("run%0d_err_cnt", r.id), 64'(err_cnt), 64'(r.e_err));
            chk($sformatf("run%0d_pass", r.id), 64'(pass), 64'(r.e_pass));
            chk($sformatf("run%0d_to_flag", r.id), 64'(to_flag), 64'(r.e_to));
            chk($sformatf("run%0d_latency", r.id), 64'(cyc - r.t0), 64'(r.e_lat));
            chk($sformatf("run%0d_vld_cycles", r.id), 64'(vcyc), 64'(r.e_vld));
            if (r.e_err != 0)
              chk($sformatf("run%0d_first_err", r.id), 64'(first_err_idx), 64'(r.e_first));
          end
          vcyc = 0;
        end
      end
    end
  end

  // Called just after a negedge; start (and any ld_* the caller set) are held for one cycle.
  task automatic launch(input vec_t v, input bit expect_done);
    exp_t r;
    int   i;
    echo_d  = v.d;
    sweep   = v.sw;
    idx_lo  = IDX_W'(v.lo);
    idx_hi  = IDX_W'(v.hi);
    timeout = TO_W'(v.to);
    start   = 1'b1;
    i = v.lo;
    idx_q.push_back(i);
    while (v.sw && i != v.hi) begin
      i = (i + 1) % DEPTH;
      idx_q.push_back(i);
    end
    if (expect_done) begin
      r = '{v.id, v.e_err, v.e_first, v.e_pass, v.e_to, v.e_lat, v.e_vld, cyc};
      sb.push_back(r);
    end
    @(negedge clk);
    start = 1'b0;
    ld_we = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((sb.size() != 0 || busy) && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (k >= 5000) begin
      n_tests++; n_fail++;
      $display("FAIL run_timeout: got busy=%0d pending=%0d, want idle", busy, sb.size());
      sb.delete();
      idx_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    vec_t             tmp;
    logic [OUT_W-1:0] lo_bits;
    int               dn0;
    bit               seen;

    //          id sw lo  hi  to   d   err f  pass to  lat  vld
    tbl[0] = '{0,  0, 0,  0,  0,   5,  0,  0, 1,   0,  8,   5};
    tbl[1] = '{1,  1, 0,  49, 0,   1,  2,  7, 0,   0,  151, 50};
    tbl[2] = '{2,  0, 3,  3,  100, 0,  1,  3, 0,   1,  103, 100};
    tbl[3] = '{3,  1, 62, 1,  0,   2,  0,  0, 1,   0,  17,  8};
    tbl[4] = '{4,  1, 5,  5,  0,   1,  0,  0, 1,   0,  4,   1};
    tbl[5] = '{5,  0, 7,  20, 0,   1,  1,  7, 0,   0,  4,   1};
    tbl[6] = '{6,  0, 4,  4,  3,   3,  0,  0, 1,   0,  6,   3};
    tbl[7] = '{7,  0, 4,  4,  2,   3,  1,  4, 0,   1,  5,   2};
    tbl[8] = '{8,  1, 30, 32, 5,   0,  3,  30, 0,  1,  22,  15};

    #12;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_in_vld", 64'(bus.dut_in_vld), 0);
    chk("rst_pass", 64'(pass), 0);
    chk("rst_to_flag", 64'(to_flag), 0);
    chk("rst_err_cnt", 64'(err_cnt), 0);
    chk("rst_first_err", 64'(first_err_idx), 0);
    chk_wide("rst_in_dat", bus.dut_in_dat, '0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      m_in[i] = rnd_vec();
      lo_bits = m_in[i][OUT_W-1:0];
      if (i == 7)  lo_bits[OUT_W-1] = ~lo_bits[OUT_W-1];
      if (i == 31) lo_bits[0] = ~lo_bits[0];
      m_exp[i] = lo_bits;
      ld_we   = 1'b1;
      ld_addr = IDX_W'(i);
      ld_in   = m_in[i];
      ld_exp  = m_exp[i];
      @(negedge clk);
    end
    ld_we = 1'b0;

    for (int t = 0; t < 9; t++) begin
      @(negedge clk);
      launch(tbl[t], 1'b1);
      wait_idle();
    end

    // Abort in WAIT: DUT never answers and there is no timeout.
    @(negedge clk);
    launch('{90, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = bus.dut_in_vld;
    end
    chk("abort_reached_wait", 64'(seen), 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_in_vld", 64'(bus.dut_in_vld), 0);
    dn0 = dn_cnt;
    idx_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk("abort_no_done", 64'(dn_cnt), 64'(dn0));
    tmp = tbl[0]; tmp.id = 91;
    launch(tmp, 1'b1);
    wait_idle();

    // start and ld_we while busy must both be ignored.
    @(negedge clk);
    tmp = tbl[0]; tmp.id = 92;
    launch(tmp, 1'b1);
    start = 1'b1; sweep = 1'b1; idx_lo = 6'd40; idx_hi = 6'd45;
    ld_we = 1'b1; ld_addr = '0; ld_in = rnd_vec(); ld_exp = '0;
    @(negedge clk);
    start = 1'b0;
    ld_we = 1'b0;
    wait_idle();
    tmp = tbl[0]; tmp.id = 93;
    launch(tmp, 1'b1);
    wait_idle();

    // Load and start in the same cycle: the run must see the new slot contents.
    @(negedge clk);
    m_in[9]  = rnd_vec();
    m_exp[9] = m_in[9][OUT_W-1:0];
    ld_we = 1'b1; ld_addr = 6'd9; ld_in = m_in[9]; ld_exp = m_exp[9];
    launch('{94, 0, 9, 9, 0, 1, 0, 0, 1, 0, 4, 1}, 1'b1);
    wait_idle();

    chk("idx_queue_drained", 64'(idx_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
